mul_mips_controller: RTL and testbench

Multicycle control unit for the multi-cycle MIPS datapath (PC, IR, data, rd1/rd2 and ALU-out registers; shared memory port).
- Moore FSM sequences fetch/decode/execute/memory/writeback and drives every datapath select and enable.
- A nested ALU decoder produces alu_con.
- Memory accesses are stretched by a mem_ready handshake, with an optional timeout watchdog.

---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/alu_decoder_mips.sv | 39 +++
 rtl/mul_mips_controller.sv | 205 ++++++++++++++++++++
 tb/tb_mul_mips_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM state
// encoding, instruction field constants, ALU control codes, datapath
// select encodings and the ALU operation class passed to the ALU decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_RTYPEEX = 4'd6,
    ST_RTYPEWB = 4'd7,
    ST_BEQEX   = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JEX     = 4'd11
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RD2    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU_RES = 2'b00;
  localparam logic [1:0] PCSRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;

  // Operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } alu_op_t;

endpackage

// File: rtl/alu_decoder_mips.sv
// Combinational ALU decoder.
// Ports:
//   alu_op  : operation class from the FSM (add / sub / decode funct)
//   funct   : instr[5:0]
//   alu_con : ALU control code
//   illegal : high when alu_op asks for funct decode and funct is unsupported
module alu_decoder_mips
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_con,
  output logic       illegal
);

  always_comb begin
    alu_con = ALU_ADD;
    illegal = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_con = ALU_ADD;
      ALUOP_SUB: alu_con = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_con = ALU_ADD;
          FN_SUB:  alu_con = ALU_SUB;
          FN_AND:  alu_con = ALU_AND;
          FN_OR:   alu_con = ALU_OR;
          FN_SLT:  alu_con = ALU_SLT;
          default: begin
            alu_con = ALU_ADD;
            illegal = 1'b1;
          end
        endcase
      end
      default: alu_con = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mul_mips_controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects and
// enables, with a memory wait handshake (mem_ready) and an optional
// watchdog on memory waits.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   opcode, funct       : instruction fields from IR
//   zero_flag           : ALU zero (branch decision)
//   mem_ready           : memory completes the current access this cycle
//   alu_con, pc_src, alu_srca, alu_srcb, mem_to_reg, reg_dst, io_rd : selects
//   reg_wr, ir_wr, pc_en, mem_wr : enables
//   illegal_instr, mem_timeout_err : one-cycle error pulses
//   state_dbg           : current state encoding
// Handshake: a memory access (FETCH, MEMRD, MEMWR) is presented every cycle
// and completes in the cycle mem_ready=1; the FSM leaves that state on the
// following edge. mem_ready is ignored outside those states.
module mul_mips_controller
  import mips_ctrl_pkg::*;
#(
  parameter int alu_con_width = 3,
  parameter int timeout_width = 8,
  parameter int mem_timeout   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               opcode,
  input  logic [5:0]               funct,
  input  logic                     zero_flag,
  input  logic                     mem_ready,
  output logic [alu_con_width-1:0] alu_con,
  output logic [1:0]               pc_src,
  output logic                     alu_srca,
  output logic [1:0]               alu_srcb,
  output logic                     mem_to_reg,
  output logic                     reg_dst,
  output logic                     reg_wr,
  output logic                     io_rd,
  output logic                     ir_wr,
  output logic                     pc_en,
  output logic                     mem_wr,
  output logic                     illegal_instr,
  output logic                     mem_timeout_err,
  output logic [3:0]               state_dbg
);

  localparam logic                     WATCHDOG_ON   = (mem_timeout > 0);
  localparam logic [timeout_width-1:0] TIMEOUT_LIMIT = timeout_width'(mem_timeout);

  state_t                   state, state_next;
  state_t                   cur;
  logic [timeout_width-1:0] wait_cnt, wait_cnt_next;
  alu_op_t                  alu_op;
  logic                     alu_en;
  logic [2:0]               dec_con;
  logic                     dec_illegal;
  logic                     mem_wait_state;
  logic                     expired;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // While in reset the outputs decode as FETCH, even before the first edge.
  assign cur = rst ? ST_FETCH : state;

  assign mem_wait_state = (cur == ST_FETCH) || (cur == ST_MEMRD) || (cur == ST_MEMWR);

  // A same-cycle mem_ready wins over expiry.
  assign expired = WATCHDOG_ON && !rst && mem_wait_state && !mem_ready &&
                   (wait_cnt == TIMEOUT_LIMIT);

  alu_decoder_mips u_alu_dec (
    .alu_op  (alu_op),
    .funct   (funct),
    .alu_con (dec_con),
    .illegal (dec_illegal)
  );

  // States that do not use the ALU drive alu_con to 0.
  assign alu_con         = alu_en ? alu_con_width'(dec_con) : '0;
  assign mem_timeout_err = expired;
  assign state_dbg       = state;

  always_comb begin
    state_next    = cur;
    alu_op        = ALUOP_ADD;
    alu_en        = 1'b0;
    pc_src        = PCSRC_ALU_RES;
    alu_srca      = 1'b0;
    alu_srcb      = SRCB_RD2;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_wr        = 1'b0;
    io_rd         = 1'b0;
    ir_wr         = 1'b0;
    pc_en         = 1'b0;
    mem_wr        = 1'b0;
    illegal_instr = 1'b0;

    case (cur)
      ST_FETCH: begin
        alu_srcb = SRCB_FOUR;
        alu_en   = 1'b1;
        ir_wr    = mem_ready;
        pc_en    = mem_ready;
        // On expiry the FSM simply stays here and retries the fetch.
        if (mem_ready) state_next = ST_DECODE;
      end
      ST_DECODE: begin
        alu_srcb = SRCB_IMM_SH;
        alu_en   = 1'b1;
        case (opcode)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE:     state_next = ST_RTYPEEX;
          OP_BEQ:       state_next = ST_BEQEX;
          OP_ADDI:      state_next = ST_ADDIEX;
          OP_J:         state_next = ST_JEX;
          default: begin
            illegal_instr = 1'b1;
            state_next    = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_srca   = 1'b1;
        alu_srcb   = SRCB_IMM;
        alu_en     = 1'b1;
        state_next = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end
      ST_MEMRD: begin
        io_rd = 1'b1;
        if (mem_ready)    state_next = ST_MEMWB;
        else if (expired) state_next = ST_FETCH;
      end
      ST_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_wr     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_MEMWR: begin
        io_rd  = 1'b1;
        mem_wr = 1'b1;
        if (mem_ready || expired) state_next = ST_FETCH;
      end
      ST_RTYPEEX: begin
        alu_srca      = 1'b1;
        alu_op        = ALUOP_FUNCT;
        alu_en        = 1'b1;
        illegal_instr = dec_illegal;
        state_next    = dec_illegal ? ST_FETCH : ST_RTYPEWB;
      end
      ST_RTYPEWB: begin
        reg_dst    = 1'b1;
        reg_wr     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_BEQEX: begin
        alu_srca   = 1'b1;
        alu_op     = ALUOP_SUB;
        alu_en     = 1'b1;
        pc_src     = PCSRC_ALU_OUT;
        pc_en      = zero_flag;
        state_next = ST_FETCH;
      end
      ST_ADDIEX: begin
        alu_srca   = 1'b1;
        alu_srcb   = SRCB_IMM;
        alu_en     = 1'b1;
        state_next = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        reg_wr     = 1'b1;
        state_next = ST_FETCH;
      end
      ST_JEX: begin
        pc_src     = PCSRC_JUMP;
        pc_en      = 1'b1;
        state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase

    if (rst) begin
      reg_wr        = 1'b0;
      ir_wr         = 1'b0;
      pc_en         = 1'b0;
      mem_wr        = 1'b0;
      illegal_instr = 1'b0;
    end

    // Wait counter: counts consecutive unanswered memory cycles in one state.
    if (!mem_wait_state || mem_ready || expired || (state_next != cur))
      wait_cnt_next = '0;
    else if (wait_cnt != '1)
      wait_cnt_next = wait_cnt + 1'b1;
    else
      wait_cnt_next = wait_cnt;
  end

endmodule

// File: tb/tb_mul_mips_controller.sv
// Testbench for mul_mips_controller: reset checks, a table of zero-wait
// instructions with independently stated latencies and pulse counts,
// directed multi-cycle sequences (wait states, watchdog, reset mid-write),
// and randomized instruction streams checked cycle by cycle against a
// behavioural model that expands each instruction into its cycles.
module tb_mul_mips_controller;
  import mips_ctrl_pkg::*;

  localparam int TMO = 4;

  typedef struct packed {
    logic [3:0] st;
    logic       ir_wr;
    logic       pc_en;
    logic       reg_wr;
    logic       mem_wr;
    logic       io_rd;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [2:0] alu_con;
    logic [1:0] pc_src;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       illegal;
    logic       err;
  } out_t;
  localparam int OUT_W = $bits(out_t);

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         exp_cyc;
    int         exp_reg_wr;
    int         exp_mem_wr;
    int         exp_illegal;
    int         exp_pc_en;
    logic [2:0] exp_con3;
  } vec_t;

  // ---------------- clock / reset / signals ----------------
  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic       mem_ready;

  logic [2:0] alu_con;
  logic [1:0] pc_src;
  logic       alu_srca;
  logic [1:0] alu_srcb;
  logic       mem_to_reg, reg_dst, reg_wr, io_rd, ir_wr, pc_en, mem_wr;
  logic       illegal_instr, mem_timeout_err;
  logic [3:0] state_dbg;

  logic [2:0] z_alu_con;
  logic [1:0] z_pc_src;
  logic       z_alu_srca;
  logic [1:0] z_alu_srcb;
  logic       z_mem_to_reg, z_reg_dst, z_reg_wr, z_io_rd, z_ir_wr, z_pc_en, z_mem_wr;
  logic       z_illegal_instr, z_mem_timeout_err;
  logic [3:0] z_state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mul_mips_controller #(.alu_con_width(3), .timeout_width(8), .mem_timeout(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .alu_con(alu_con), .pc_src(pc_src), .alu_srca(alu_srca),
    .alu_srcb(alu_srcb), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_wr(reg_wr),
    .io_rd(io_rd), .ir_wr(ir_wr), .pc_en(pc_en), .mem_wr(mem_wr),
    .illegal_instr(illegal_instr), .mem_timeout_err(mem_timeout_err), .state_dbg(state_dbg)
  );

  // Watchdog disabled (default parameters), shares all inputs.
  mul_mips_controller dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .alu_con(z_alu_con), .pc_src(z_pc_src), .alu_srca(z_alu_srca),
    .alu_srcb(z_alu_srcb), .mem_to_reg(z_mem_to_reg), .reg_dst(z_reg_dst), .reg_wr(z_reg_wr),
    .io_rd(z_io_rd), .ir_wr(z_ir_wr), .pc_en(z_pc_en), .mem_wr(z_mem_wr),
    .illegal_instr(z_illegal_instr), .mem_timeout_err(z_mem_timeout_err), .state_dbg(z_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [1:0]       stim_q[$];   // {mem_ready, zero_flag} per cycle

  int         t_cyc, t_reg_wr, t_mem_wr, t_illegal, t_pc_en, t_err;
  logic [2:0] t_con3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic out_t dut_out();
    out_t a;
    a.st = state_dbg; a.ir_wr = ir_wr; a.pc_en = pc_en; a.reg_wr = reg_wr;
    a.mem_wr = mem_wr; a.io_rd = io_rd; a.alu_srca = alu_srca; a.alu_srcb = alu_srcb;
    a.alu_con = alu_con; a.pc_src = pc_src; a.mem_to_reg = mem_to_reg;
    a.reg_dst = reg_dst; a.illegal = illegal_instr; a.err = mem_timeout_err;
    return a;
  endfunction

  // ---------------- reference model ----------------
  function automatic bit funct_ok(input logic [5:0] fn, output logic [2:0] con);
    case (fn)
      6'b100000: begin con = 3'b010; return 1'b1; end
      6'b100010: begin con = 3'b110; return 1'b1; end
      6'b100100: begin con = 3'b000; return 1'b1; end
      6'b100101: begin con = 3'b001; return 1'b1; end
      6'b101010: begin con = 3'b111; return 1'b1; end
      default:   begin con = 3'b010; return 1'b0; end
    endcase
  endfunction

  // Output table per state, written directly from the control description.
  function automatic logic [OUT_W-1:0] spec_out(input state_t st, input logic [5:0] op,
      input logic [5:0] fn, input logic rdy, input logic z, input logic err);
    out_t o;
    logic [2:0] con;
    bit ok;
    o = '0;
    o.st = st;
    o.err = err;
    case (st)
      ST_FETCH:   begin o.alu_srcb = 2'b01; o.alu_con = 3'b010; o.ir_wr = rdy; o.pc_en = rdy; end
      ST_DECODE:  begin
        o.alu_srcb = 2'b11; o.alu_con = 3'b010;
        o.illegal = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
      end
      ST_MEMADR:  begin o.alu_srca = 1'b1; o.alu_srcb = 2'b10; o.alu_con = 3'b010; end
      ST_MEMRD:   o.io_rd = 1'b1;
      ST_MEMWB:   begin o.mem_to_reg = 1'b1; o.reg_wr = 1'b1; end
      ST_MEMWR:   begin o.io_rd = 1'b1; o.mem_wr = 1'b1; end
      ST_RTYPEEX: begin
        ok = funct_ok(fn, con);
        o.alu_srca = 1'b1; o.alu_con = con; o.illegal = !ok;
      end
      ST_RTYPEWB: begin o.reg_dst = 1'b1; o.reg_wr = 1'b1; end
      ST_BEQEX:   begin o.alu_srca = 1'b1; o.alu_con = 3'b110; o.pc_src = 2'b01; o.pc_en = z; end
      ST_ADDIEX:  begin o.alu_srca = 1'b1; o.alu_srcb = 2'b10; o.alu_con = 3'b010; end
      ST_ADDIWB:  o.reg_wr = 1'b1;
      ST_JEX:     begin o.pc_src = 2'b10; o.pc_en = 1'b1; end
      default:    o = '0;
    endcase
    return o;
  endfunction

  task automatic push(input state_t st, input logic rdy, input logic z, input logic err,
                      input logic [5:0] op, input logic [5:0] fn);
    stim_q.push_back({rdy, z});
    exp_q.push_back(spec_out(st, op, fn, rdy, z, err));
  endtask

  // A memory access with w unanswered cycles; the watchdog fires on the
  // (TMO+1)-th unanswered cycle unless mem_ready arrives in that cycle.
  task automatic mem_phase(input state_t st, input int w, input logic [5:0] op,
                           input logic [5:0] fn, input logic z, output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i <= w; i++) begin
      if (i < w && i == TMO) begin
        push(st, 1'b0, z, 1'b1, op, fn);
        aborted = 1'b1;
        return;
      end
      push(st, (i == w), z, 1'b0, op, fn);
    end
  endtask

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its expected cycles.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
    bit ab;
    logic [2:0] con;
    int w;
    w = fw;
    do begin
      mem_phase(ST_FETCH, w, op, fn, z, ab);
      w = 0;
    end while (ab);
    push(ST_DECODE, rnd_bit(), z, 1'b0, op, fn);
    case (op)
      6'b100011: begin
        push(ST_MEMADR, rnd_bit(), z, 1'b0, op, fn);
        mem_phase(ST_MEMRD, mw, op, fn, z, ab);
        if (!ab) push(ST_MEMWB, rnd_bit(), z, 1'b0, op, fn);
      end
      6'b101011: begin
        push(ST_MEMADR, rnd_bit(), z, 1'b0, op, fn);
        mem_phase(ST_MEMWR, mw, op, fn, z, ab);
      end
      6'b000000: begin
        push(ST_RTYPEEX, rnd_bit(), z, 1'b0, op, fn);
        if (funct_ok(fn, con)) push(ST_RTYPEWB, rnd_bit(), z, 1'b0, op, fn);
      end
      6'b000100: push(ST_BEQEX, rnd_bit(), z, 1'b0, op, fn);
      6'b001000: begin
        push(ST_ADDIEX, rnd_bit(), z, 1'b0, op, fn);
        push(ST_ADDIWB, rnd_bit(), z, 1'b0, op, fn);
      end
      6'b000010: push(ST_JEX, rnd_bit(), z, 1'b0, op, fn);
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1 with the DUT expected in FETCH; returns likewise.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    logic [1:0] s;
    logic [OUT_W-1:0] e;
    out_t a;
    build(op, fn, z, fw, mw);
    opcode = op;
    funct  = fn;
    t_cyc = 0; t_reg_wr = 0; t_mem_wr = 0; t_illegal = 0; t_pc_en = 0; t_err = 0;
    t_con3 = 3'bxxx;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      mem_ready = s[1];
      zero_flag = s[0];
      @(negedge clk);
      a = dut_out();
      check("cycle_outputs", 32'(a), 32'(e));
      check("nowdog_err", 32'(z_mem_timeout_err), 32'd0);
      if (t_cyc == 2) t_con3 = a.alu_con;
      t_reg_wr  += int'(a.reg_wr);
      t_mem_wr  += int'(a.mem_wr);
      t_illegal += int'(a.illegal);
      t_pc_en   += int'(a.pc_en);
      t_err     += int'(a.err);
      t_cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[13];

  initial begin
    logic [5:0] ops[8];
    logic [5:0] fns[6];
    logic [5:0] rop, rfn;
    int fw, mw;

    vecs[0]  = '{6'b100011, 6'b000000, 1'b0, 5, 1, 0, 0, 1, 3'b010};
    vecs[1]  = '{6'b101011, 6'b000000, 1'b0, 4, 0, 1, 0, 1, 3'b010};
    vecs[2]  = '{6'b000000, 6'b100000, 1'b0, 4, 1, 0, 0, 1, 3'b010};
    vecs[3]  = '{6'b000000, 6'b100010, 1'b1, 4, 1, 0, 0, 1, 3'b110};
    vecs[4]  = '{6'b000000, 6'b100100, 1'b0, 4, 1, 0, 0, 1, 3'b000};
    vecs[5]  = '{6'b000000, 6'b100101, 1'b0, 4, 1, 0, 0, 1, 3'b001};
    vecs[6]  = '{6'b000000, 6'b101010, 1'b0, 4, 1, 0, 0, 1, 3'b111};
    vecs[7]  = '{6'b000000, 6'b000111, 1'b0, 3, 0, 0, 1, 1, 3'b010};
    vecs[8]  = '{6'b000100, 6'b000000, 1'b1, 3, 0, 0, 0, 2, 3'b110};
    vecs[9]  = '{6'b000100, 6'b000000, 1'b0, 3, 0, 0, 0, 1, 3'b110};
    vecs[10] = '{6'b001000, 6'b000000, 1'b0, 4, 1, 0, 0, 1, 3'b010};
    vecs[11] = '{6'b000010, 6'b000000, 1'b1, 3, 0, 0, 0, 2, 3'b000};
    vecs[12] = '{6'b111111, 6'b000000, 1'b0, 2, 0, 0, 1, 1, 3'b010};

    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010,
            6'b111111, 6'b001101};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000111};

    // Reset: selects at FETCH values, enables held low even with mem_ready=1.
    rst = 1'b1; opcode = 6'b100011; funct = 6'b0; zero_flag = 1'b1; mem_ready = 1'b1;
    #1;
    check("rst_ir_wr", 32'(ir_wr), 32'd0);
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_reg_wr", 32'(reg_wr), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_alu_srcb", 32'(alu_srcb), 32'h1);
    check("rst_alu_con", 32'(alu_con), 32'h2);
    check("rst_io_rd", 32'(io_rd), 32'd0);
    @(posedge clk); #1;
    check("rst_state", 32'(state_dbg), 32'(ST_FETCH));
    check("rst_ir_wr_after_edge", 32'(ir_wr), 32'd0);
    check("rst_err", 32'(mem_timeout_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table of zero-wait instructions.
    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, 0, 0);
      check($sformatf("vec%0d_cycles", i), 32'(t_cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("vec%0d_reg_wr", i), 32'(t_reg_wr), 32'(vecs[i].exp_reg_wr));
      check($sformatf("vec%0d_mem_wr", i), 32'(t_mem_wr), 32'(vecs[i].exp_mem_wr));
      check($sformatf("vec%0d_illegal", i), 32'(t_illegal), 32'(vecs[i].exp_illegal));
      check($sformatf("vec%0d_pc_en", i), 32'(t_pc_en), 32'(vecs[i].exp_pc_en));
      if (vecs[i].exp_cyc >= 3)
        check($sformatf("vec%0d_exec_alu_con", i), 32'(t_con3), 32'(vecs[i].exp_con3));
    end

    // sw with 3 wait cycles in MEMWR.
    run_instr(6'b101011, 6'b0, 1'b0, 0, 3);
    check("sw_wait_cycles", 32'(t_cyc), 32'd7);
    check("sw_wait_mem_wr", 32'(t_mem_wr), 32'd4);

    // lw with mem_ready stuck low: watchdog aborts after the 5th wait cycle.
    run_instr(6'b100011, 6'b0, 1'b0, 0, 20);
    check("lw_tmo_err", 32'(t_err), 32'd1);
    check("lw_tmo_cycles", 32'(t_cyc), 32'd8);
    check("lw_tmo_reg_wr", 32'(t_reg_wr), 32'd0);
    check("lw_tmo_back_fetch", 32'(state_dbg), 32'(ST_FETCH));
    check("nowdog_still_memrd", 32'(z_state_dbg), 32'(ST_MEMRD));

    // Fetch expiry then retry; then ready exactly on the expiry cycle.
    run_instr(6'b000010, 6'b0, 1'b0, 6, 0);
    check("fetch_tmo_err", 32'(t_err), 32'd1);
    check("fetch_tmo_cycles", 32'(t_cyc), 32'd8);
    run_instr(6'b101011, 6'b0, 1'b0, 0, TMO);
    check("ready_on_expiry_err", 32'(t_err), 32'd0);

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      rop = ops[$urandom_range(0, 7)];
      rfn = fns[$urandom_range(0, 5)];
      fw  = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
      mw  = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      run_instr(rop, rfn, rnd_bit(), fw, mw);
    end

    // Reset asserted while in MEMWR.
    opcode = 6'b101011; funct = 6'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_state_memwr", 32'(state_dbg), 32'(ST_MEMWR));
    check("pre_rst_mem_wr", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
    check("mid_rst_io_rd", 32'(io_rd), 32'd0);
    @(posedge clk); #1;
    check("post_rst_state", 32'(state_dbg), 32'(ST_FETCH));
    check("post_rst_z_state", 32'(z_state_dbg), 32'(ST_FETCH));
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
